// File: rtl/jk_pkg.sv
// Shared types for the JK drive sequencer: command opcodes ({j,k} encoding) and FSM states.
package jk_pkg;

   localparam int JK_OP_W = 2;

   typedef enum logic [JK_OP_W-1:0] {
      OP_HOLD   = 2'b00,
      OP_RESET  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } jk_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRIVE = 2'b01,
      ST_FIN   = 2'b10
   } seq_state_e;

endpackage

// File: rtl/jk_ref_model.sv
// Per-lane expected-state model of the downstream JK flop bank, with a sticky Q compare.
module jk_ref_model
   import jk_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] mismatch
);

   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] exp_vld;

   // NOTE: exp_q is reset along with exp_vld even though its value is ignored
   // until a lane is SET/RESET; this keeps the state deterministic for compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q    <= '0;
         exp_vld  <= '0;
         mismatch <= '0;
      end else begin
         // Compare uses the model value for the current cycle, before this edge updates it.
         mismatch <= mismatch | (exp_vld & (q_fb ^ exp_q));
         for (int i = 0; i < WIDTH; i++) begin
            case (jk_op_e'({j[i], k[i]}))
               OP_SET: begin
                  exp_q[i]   <= 1'b1;
                  exp_vld[i] <= 1'b1;
               end
               OP_RESET: begin
                  exp_q[i]   <= 1'b0;
                  exp_vld[i] <= 1'b1;
               end
               OP_TOGGLE: exp_q[i] <= ~exp_q[i];
               default:   ;
            endcase
         end
      end
   end

endmodule

// File: rtl/jk_drive_seq.sv
// Command sequencer driving j/k of a JK flop bank for a programmed number of cycles.
// Define JK_CHECK_EN to enable the per-lane Q feedback checker (jk_ref_model).
module jk_drive_seq
   import jk_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [JK_OP_W-1:0] cmd_op,
   input  logic [WIDTH-1:0]   cmd_mask,
   input  logic [LEN_W-1:0]   cmd_len,
   output logic [WIDTH-1:0]   j,
   output logic [WIDTH-1:0]   k,
   output logic               busy,
   output logic               done,
   input  logic [WIDTH-1:0]   q_fb,
   output logic [WIDTH-1:0]   mismatch
);

   seq_state_e       state, state_nx;
   logic [LEN_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] j_nx, k_nx;
   logic             accept;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state == ST_DRIVE);
   assign done      = ((state == ST_DRIVE) && (cnt == LEN_W'(1))) || (state == ST_FIN);
   assign accept    = cmd_valid && cmd_ready;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      j_nx     = j;
      k_nx     = k;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_len != '0) begin
                  j_nx     = cmd_mask & {WIDTH{cmd_op[1]}};
                  k_nx     = cmd_mask & {WIDTH{cmd_op[0]}};
                  cnt_nx   = cmd_len;
                  state_nx = ST_DRIVE;
               end else begin
                  state_nx = ST_FIN;
               end
            end
         end
         ST_DRIVE: begin
            // cnt ends at 0 on exit, so it never wraps while idle.
            cnt_nx = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
               j_nx     = '0;
               k_nx     = '0;
               state_nx = ST_IDLE;
            end
         end
         ST_FIN: state_nx = ST_IDLE;
         default: begin
            j_nx     = '0;
            k_nx     = '0;
            cnt_nx   = '0;
            state_nx = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         j     <= '0;
         k     <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         j     <= j_nx;
         k     <= k_nx;
      end
   end

`ifdef JK_CHECK_EN
   jk_ref_model #(
      .WIDTH (WIDTH)
   ) u_ref_model (
      .clk      (clk),
      .rst_n    (rst_n),
      .j        (j),
      .k        (k),
      .q_fb     (q_fb),
      .mismatch (mismatch)
   );
`else
   logic unused_q_fb;

   assign unused_q_fb = ^q_fb;
   assign mismatch    = '0;
`endif

endmodule
